spi_dac_tx: RTL

SPI transmitter that serializes 32-bit DAC sample words onto a 3-wire write-only SPI bus (SCLK, MOSI, CS_N). It sits directly downstream of the sine sample generator, taking its 32-bit `sinout` word through a valid/ready handshake and driving the external DAC pins. One accepted word produces one chip-select frame, shifted MSB first in SPI mode 0.

---
 rtl/spi_dac_if.sv | 24 ++
 rtl/spi_dac_tx.sv | 111 +++++++++++
 2 files changed

// File: rtl/spi_dac_if.sv
// Sample-word handshake plus DAC pin bundle between the sine generator,
// the SPI transmitter and the external DAC.
interface spi_dac_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;

  modport master (
    output din, din_valid,
    input  din_ready, sclk, mosi, cs_n, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sclk, mosi, cs_n, busy, done
  );
endinterface

// File: rtl/spi_dac_tx.sv
// Write-only SPI mode-0 transmitter: one accepted word becomes one CS_N frame,
// shifted MSB first, with a SETUP half-period before the first SCLK rise.
module spi_dac_tx #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic     clk,
  input  logic     reset,
  spi_dac_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  // One counter serves both the SCLK half-periods and the CS gap.
  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitcnt;
  logic              tail;
  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bitcnt        <= '0;
      tail          <= 1'b0;
      shreg         <= '0;
      bus.sclk      <= 1'b0;
      bus.mosi      <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.din_ready <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.din_ready <= 1'b1;
          cnt           <= '0;
          bitcnt        <= '0;
          tail          <= 1'b0;
          if (bus.din_valid && bus.din_ready) begin
            shreg         <= bus.din;
            bus.mosi      <= bus.din[DATA_W-1];
            bus.cs_n      <= 1'b0;
            bus.busy      <= 1'b1;
            bus.din_ready <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            bus.sclk <= 1'b1;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (bus.sclk) begin
              // Falling edge: present the next bit, or idle MOSI after bit 0.
              bus.sclk <= 1'b0;
              shreg    <= shreg << 1;
              if (bitcnt == BIT_LAST) begin
                bus.mosi <= 1'b0;
                tail     <= 1'b1;
              end else begin
                bus.mosi <= shreg[DATA_W-2];
                bitcnt   <= bitcnt + 1'b1;
              end
            end else if (tail) begin
              bus.cs_n <= 1'b1;
              bus.done <= 1'b1;
              state    <= GAP;
            end else begin
              bus.sclk <= 1'b1;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            bus.busy      <= 1'b0;
            bus.din_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
